// File: rtl/m3_pkg.sv
// Shared types and constants for the M3 motor ramp sequencer.
//   m3State_t      : sequencer state encoding (also driven out on stateO)
//   F_*_DEF/P_*_DEF: default frequency / power code limits
//   satStep        : saturating +/-step of a target on INC/DEC presses
//   stepToward     : single-unit move of a code toward a goal, no overshoot
package m3_pkg;

    localparam int unsigned CODE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        REVERSE   = 3'd4
    } m3State_t;

    localparam logic [CODE_W-1:0] F_MIN_DEF = 8'd10;
    localparam logic [CODE_W-1:0] F_DEF_DEF = 8'd20;
    localparam logic [CODE_W-1:0] F_MAX_DEF = 8'd200;
    localparam logic [CODE_W-1:0] P_MIN_DEF = 8'd5;
    localparam logic [CODE_W-1:0] P_DEF_DEF = 8'd8;
    localparam logic [CODE_W-1:0] P_MAX_DEF = 8'd250;

    // INC and DEC together cancel; 9-bit math keeps the saturation free of wrap.
    function automatic logic [CODE_W-1:0] satStep(
        input logic [CODE_W-1:0] v,
        input logic              inc,
        input logic              dec,
        input logic [CODE_W-1:0] step,
        input logic [CODE_W-1:0] lo,
        input logic [CODE_W-1:0] hi
    );
        logic [CODE_W:0] sum;
        logic [CODE_W:0] floorVal;
        sum      = {1'b0, v} + {1'b0, step};
        floorVal = {1'b0, lo} + {1'b0, step};
        satStep  = v;
        if (inc && !dec) begin
            satStep = (sum > {1'b0, hi}) ? hi : sum[CODE_W-1:0];
        end else if (dec && !inc) begin
            satStep = ({1'b0, v} < floorVal) ? lo : (v - step);
        end
    endfunction

    function automatic logic [CODE_W-1:0] stepToward(
        input logic [CODE_W-1:0] v,
        input logic [CODE_W-1:0] goal
    );
        if (v < goal)      stepToward = v + 8'd1;
        else if (v > goal) stepToward = v - 8'd1;
        else               stepToward = v;
    endfunction

endpackage

// File: rtl/m3_edge_det.sv
// Rising-edge detector with registered one-cycle pulse output.
//   clkI   : clock
//   rstI   : synchronous active-high reset
//   sigI   : synchronous level input
//   pulseO : one-cycle pulse, the cycle after sigI rises
// History resets to 1 so a level held high through reset is not a press.
module m3_edge_det (
    input  logic clkI,
    input  logic rstI,
    input  logic sigI,
    output logic pulseO
);

    logic prev;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            prev   <= 1'b1;
            pulseO <= 1'b0;
        end else begin
            prev   <= sigI;
            pulseO <= sigI & ~prev;
        end
    end

endmodule

// File: rtl/m3_ramp_seq.sv
// Three-phase motor start/stop/reverse ramp sequencer.
//   clkI, rstI            : clock, synchronous active-high reset
//   m3startI              : start / stop request (edge detected)
//   m3forceStopI          : level, forces IDLE and blocks start while high
//   m3invRotateI          : reverse request (edge detected)
//   m3freqINCi/DECi       : frequency target +/- STEP (edge detected)
//   m3powerINCi/DECi      : power target +/- STEP (edge detected)
//   freqO, powerO         : commanded frequency / power codes
//   runO, dirO, stateO    : driver enable, rotation direction, state code
module m3_ramp_seq
    import m3_pkg::*;
#(
    parameter int unsigned     TICK_DIV   = 1000,
    parameter logic [7:0]      F_MIN      = F_MIN_DEF,
    parameter logic [7:0]      F_DEF      = F_DEF_DEF,
    parameter logic [7:0]      F_MAX      = F_MAX_DEF,
    parameter logic [7:0]      P_MIN      = P_MIN_DEF,
    parameter logic [7:0]      P_DEF      = P_DEF_DEF,
    parameter logic [7:0]      P_MAX      = P_MAX_DEF,
    parameter logic [7:0]      STEP       = 8'd2,
    parameter int unsigned     DEAD_TICKS = 3
) (
    input  logic       clkI,
    input  logic       rstI,
    input  logic       m3startI,
    input  logic       m3forceStopI,
    input  logic       m3invRotateI,
    input  logic       m3freqINCi,
    input  logic       m3freqDECi,
    input  logic       m3powerINCi,
    input  logic       m3powerDECi,
    output logic [7:0] freqO,
    output logic [7:0] powerO,
    output logic       runO,
    output logic       dirO,
    output logic [2:0] stateO
);

    localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

    // Elaboration-time parameter legality.
    if (!((F_MIN <= F_DEF) && (F_DEF <= F_MAX))) begin : gBadFreq
        $error("m3_ramp_seq: need F_MIN <= F_DEF <= F_MAX");
    end
    if (!((P_MIN <= P_DEF) && (P_DEF <= P_MAX))) begin : gBadPower
        $error("m3_ramp_seq: need P_MIN <= P_DEF <= P_MAX");
    end
    if (TICK_DIV < 2) begin : gBadTick
        $error("m3_ramp_seq: TICK_DIV must be >= 2");
    end
    if (DEAD_TICKS < 1) begin : gBadDead
        $error("m3_ramp_seq: DEAD_TICKS must be >= 1");
    end

    // Press pulses.
    logic startP, invP, fIncP, fDecP, pIncP, pDecP;

    m3_edge_det uStartEd (.clkI(clkI), .rstI(rstI), .sigI(m3startI),     .pulseO(startP));
    m3_edge_det uInvEd   (.clkI(clkI), .rstI(rstI), .sigI(m3invRotateI), .pulseO(invP));
    m3_edge_det uFIncEd  (.clkI(clkI), .rstI(rstI), .sigI(m3freqINCi),   .pulseO(fIncP));
    m3_edge_det uFDecEd  (.clkI(clkI), .rstI(rstI), .sigI(m3freqDECi),   .pulseO(fDecP));
    m3_edge_det uPIncEd  (.clkI(clkI), .rstI(rstI), .sigI(m3powerINCi),  .pulseO(pIncP));
    m3_edge_det uPDecEd  (.clkI(clkI), .rstI(rstI), .sigI(m3powerDECi),  .pulseO(pDecP));

    // Free-running ramp tick.
    logic [CNT_W-1:0] tickCnt;
    logic             tickC;

    assign tickC = (tickCnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clkI) begin
        if (rstI)       tickCnt <= '0;
        else if (tickC) tickCnt <= '0;
        else            tickCnt <= tickCnt + CNT_W'(1);
    end

    // Targets follow presses in every state, forceStop included.
    logic [7:0] fTgt, pTgt;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            fTgt <= F_DEF;
            pTgt <= P_DEF;
        end else begin
            fTgt <= satStep(fTgt, fIncP, fDecP, STEP, F_MIN, F_MAX);
            pTgt <= satStep(pTgt, pIncP, pDecP, STEP, P_MIN, P_MAX);
        end
    end

    // Sequencer state and registered outputs.
    m3State_t          state, stateN;
    logic [7:0]        freqN, powerN;
    logic              runN, dirN;
    logic              revPending, revN;
    logic [DEAD_W-1:0] deadCnt, deadN;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            state      <= IDLE;
            freqO      <= '0;
            powerO     <= '0;
            runO       <= 1'b0;
            dirO       <= 1'b0;
            revPending <= 1'b0;
            deadCnt    <= '0;
        end else begin
            state      <= stateN;
            freqO      <= freqN;
            powerO     <= powerN;
            runO       <= runN;
            dirO       <= dirN;
            revPending <= revN;
            deadCnt    <= deadN;
        end
    end

    assign stateO = state;

    // Next state / next outputs; forceStop outranks start, start outranks invRotate.
    always_comb begin
        stateN = state;
        freqN  = freqO;
        powerN = powerO;
        runN   = runO;
        dirN   = dirO;
        revN   = revPending;
        deadN  = deadCnt;

        if (m3forceStopI) begin
            stateN = IDLE;
            freqN  = '0;
            powerN = '0;
            runN   = 1'b0;
            revN   = 1'b0;
            deadN  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startP) begin
                        stateN = RAMP_UP;
                        freqN  = F_MIN;
                        powerN = P_MIN;
                        runN   = 1'b1;
                    end else if (invP) begin
                        dirN = ~dirO;
                    end
                end
                RAMP_UP, RUN: begin
                    if (startP) begin
                        stateN = RAMP_DOWN;
                    end else if (invP) begin
                        revN   = 1'b1;
                        stateN = RAMP_DOWN;
                    end else begin
                        if ((state == RAMP_UP) && (freqO == fTgt) && (powerO == pTgt))
                            stateN = RUN;
                        if (tickC) begin
                            freqN  = stepToward(freqO, fTgt);
                            powerN = stepToward(powerO, pTgt);
                        end
                    end
                end
                RAMP_DOWN: begin
                    if ((freqO == F_MIN) && (powerO == P_MIN)) begin
                        stateN = revPending ? REVERSE : IDLE;
                        freqN  = '0;
                        powerN = '0;
                        runN   = 1'b0;
                        deadN  = '0;
                    end else if (tickC) begin
                        freqN  = stepToward(freqO, F_MIN);
                        powerN = stepToward(powerO, P_MIN);
                    end
                end
                REVERSE: begin
                    // Dead time with the driver off before restarting the other way.
                    if (tickC) begin
                        if (deadCnt == DEAD_W'(DEAD_TICKS - 1)) begin
                            stateN = RAMP_UP;
                            dirN   = ~dirO;
                            revN   = 1'b0;
                            freqN  = F_MIN;
                            powerN = P_MIN;
                            runN   = 1'b1;
                            deadN  = '0;
                        end else begin
                            deadN = deadCnt + DEAD_W'(1);
                        end
                    end
                end
                default: begin
                    stateN = IDLE;
                    freqN  = '0;
                    powerN = '0;
                    runN   = 1'b0;
                    revN   = 1'b0;
                    deadN  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m3_ramp_seq.sv
// Directed self-checking bench for m3_ramp_seq with a short tick divider.
module tb_m3_ramp_seq;

    logic       clkI = 1'b0;
    logic       rstI;
    logic       m3startI, m3forceStopI, m3invRotateI;
    logic       m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi;
    logic [7:0] freqO, powerO;
    logic       runO, dirO;
    logic [2:0] stateO;

    int nVec = 0;
    int nErr = 0;

    always #5 clkI = ~clkI;

    m3_ramp_seq #(
        .TICK_DIV(4), .F_MIN(8'd10), .F_DEF(8'd20), .F_MAX(8'd30),
        .P_MIN(8'd5), .P_DEF(8'd8), .P_MAX(8'd12), .STEP(8'd2), .DEAD_TICKS(3)
    ) dut (
        .clkI(clkI), .rstI(rstI),
        .m3startI(m3startI), .m3forceStopI(m3forceStopI), .m3invRotateI(m3invRotateI),
        .m3freqINCi(m3freqINCi), .m3freqDECi(m3freqDECi),
        .m3powerINCi(m3powerINCi), .m3powerDECi(m3powerDECi),
        .freqO(freqO), .powerO(powerO), .runO(runO), .dirO(dirO), .stateO(stateO)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nVec++;
        if (got != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks, land 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clkI);
        #1;
    endtask

    task automatic setIn(input int which, input logic v);
        case (which)
            0: m3startI     = v;
            1: m3invRotateI = v;
            2: m3freqINCi   = v;
            3: m3freqDECi   = v;
            4: m3powerINCi  = v;
            5: m3powerDECi  = v;
            default: ;
        endcase
    endtask

    task automatic press(input int which);
        setIn(which, 1'b1);
        cyc(2);
        setIn(which, 1'b0);
        cyc(2);
    endtask

    task automatic waitState(input int s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (int'(stateO) == s) break;
            cyc(1);
        end
        chk(tag, int'(stateO), s);
    endtask

    task automatic chkOuts(input string tag, input int st, input int f, input int p,
                           input int r, input int d);
        chk({tag, ".state"}, int'(stateO), st);
        chk({tag, ".freq"},  int'(freqO),  f);
        chk({tag, ".power"}, int'(powerO), p);
        chk({tag, ".run"},   int'(runO),   r);
        chk({tag, ".dir"},   int'(dirO),   d);
    endtask

    int elapsed, prevF, prevP, cnt, bad;

    initial begin
        rstI = 1'b1;
        m3startI = 1'b1;  // held high through reset: must not count as a press
        m3forceStopI = 1'b0; m3invRotateI = 1'b0;
        m3freqINCi = 1'b0; m3freqDECi = 1'b0; m3powerINCi = 1'b0; m3powerDECi = 1'b0;
        cyc(3);
        chkOuts("reset", 0, 0, 0, 0, 0);
        rstI = 1'b0;
        cyc(4);
        chk("noPressFromHeldStart", int'(stateO), 0);
        m3startI = 1'b0;
        cyc(2);

        // invRotate in IDLE toggles direction immediately
        press(1);
        chk("idleInvDir1", int'(dirO), 1);
        chk("idleInvState", int'(stateO), 0);
        press(1);
        chk("idleInvDir0", int'(dirO), 0);

        // Start: 10/5 -> 20/8, power done after 3 ticks, RUN after 10 ticks
        m3startI = 1'b1;
        waitState(1, 10, "startToRampUp");
        chkOuts("rampUpEntry", 1, 10, 5, 1, 0);
        m3startI = 1'b0;
        elapsed = 0;
        while (powerO != 8'd8 && elapsed < 100) begin cyc(1); elapsed++; end
        chk("freqWhenPowerAt8", int'(freqO), 13);
        while (stateO != 3'd2 && elapsed < 100) begin cyc(1); elapsed++; end
        chk("rampUpCyclesInRange", int'(elapsed >= 38 && elapsed <= 41), 1);
        chkOuts("runReached", 2, 20, 8, 1, 0);

        // Saturation: six freqINC -> 30, three powerINC -> 12
        for (int i = 0; i < 6; i++) press(2);
        for (int i = 0; i < 3; i++) press(4);
        cyc(120);
        chkOuts("satMax", 2, 30, 12, 1, 0);
        for (int i = 0; i < 5; i++) press(3);
        for (int i = 0; i < 2; i++) press(5);
        cyc(120);
        chkOuts("backTo20_8", 2, 20, 8, 1, 0);

        // INC and DEC together leave targets unchanged
        m3freqINCi = 1'b1; m3freqDECi = 1'b1; m3powerINCi = 1'b1; m3powerDECi = 1'b1;
        cyc(2);
        m3freqINCi = 1'b0; m3freqDECi = 1'b0; m3powerINCi = 1'b0; m3powerDECi = 1'b0;
        cyc(24);
        chk("incDecFreq", int'(freqO), 20);
        chk("incDecPower", int'(powerO), 8);

        // Reverse: ramp down to 10/5, 3 dead ticks, dir flips, ramp back up
        press(1);
        waitState(3, 10, "invToRampDown");
        chk("dirHeldInRampDown", int'(dirO), 0);
        prevF = int'(freqO); prevP = int'(powerO);
        for (int i = 0; i < 100; i++) begin
            if (stateO != 3'd3) break;
            prevF = int'(freqO); prevP = int'(powerO);
            cyc(1);
        end
        chk("rampDownEndFreq", prevF, 10);
        chk("rampDownEndPower", prevP, 5);
        chkOuts("reverseEntry", 4, 0, 0, 0, 0);
        cnt = 0; bad = 0;
        while (stateO == 3'd4 && cnt < 50) begin
            if (freqO != 8'd0 || powerO != 8'd0 || runO != 1'b0) bad++;
            cnt++;
            cyc(1);
        end
        chk("reverseCyclesInRange", int'(cnt >= 9 && cnt <= 12), 1);
        chk("reverseOutputsOff", bad, 0);
        chkOuts("reverseExit", 1, 10, 5, 1, 1);
        waitState(2, 100, "reRampRun");
        chkOuts("reRampDone", 2, 20, 8, 1, 1);

        // Stop request ramps down to IDLE, direction kept
        press(0);
        waitState(0, 100, "stopToIdle");
        chkOuts("stopped", 0, 0, 0, 0, 1);

        // forceStop mid RAMP_UP with start held high
        m3startI = 1'b1;
        waitState(1, 10, "restartRampUp");
        cyc(10);
        chk("stillRampUp", int'(stateO), 1);
        m3forceStopI = 1'b1;
        cyc(1);
        chkOuts("forceStop", 0, 0, 0, 0, 1);
        cyc(3);
        m3startI = 1'b0;
        cyc(2);
        m3startI = 1'b1;
        cyc(5);
        chk("startBlockedByForce", int'(stateO), 0);
        m3forceStopI = 1'b0;
        cyc(10);
        chk("noRestartWithoutEdge", int'(stateO), 0);
        m3startI = 1'b0;
        cyc(2);
        m3startI = 1'b1;
        waitState(1, 10, "restartAfterForce");
        m3startI = 1'b0;
        chk("dirAfterForce", int'(dirO), 1);

        // Reset while running restores defaults
        waitState(2, 100, "runBeforeReset");
        press(2);
        press(4);
        rstI = 1'b1;
        cyc(1);
        chkOuts("resetInRun", 0, 0, 0, 0, 0);
        rstI = 1'b0;
        cyc(2);
        press(0);
        waitState(1, 10, "startAfterReset");
        waitState(2, 100, "runAfterReset");
        chkOuts("defaultsAfterReset", 2, 20, 8, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/m3_ramp_seq.md
M3_RAMP_SEQ -- requirements
Module: m3_ramp_seq

Interface
REQ-001 Parameter TICK_DIV, 1000, clkI cycles per ramp step (1 ms at 1 MHz).
REQ-002 Parameter F_MIN, 8'd10, lowest running frequency code.
REQ-003 Parameter F_DEF, 8'd20, frequency target after reset.
REQ-004 Parameter F_MAX, 8'd200, highest frequency target.
REQ-005 Parameter P_MIN, 8'd5 / P_DEF, 8'd8 / P_MAX, 8'd250, power code min / reset target / max.
REQ-006 Parameter STEP, 8'd2, target change per INC/DEC press; DEAD_TICKS, 3, outputs-off ticks before reversal.
REQ-007 Ports clkI input 1 (only clock) and rstI input 1 (reset), with reset synchronous and active-high.
REQ-008 Ports m3startI, m3forceStopI, m3invRotateI, m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi: inputs, 1 bit each, synchronous levels.
REQ-009 Ports freqO output 8, powerO output 8: commanded frequency and power codes for the three-phase driver.
REQ-010 Ports runO output 1 (driver enable), dirO output 1 (rotation direction), stateO output 3 (current state code).

Function
REQ-011 Every non-forceStop input SHALL be rising-edge detected; a press is one pulse, registered one cycle after the edge.
REQ-012 A tick SHALL be produced by a free-running counter 0..TICK_DIV-1 that pulses when it wraps.
REQ-013 Targets fTgt/pTgt SHALL change by STEP per INC/DEC pulse in any state, saturating at F_MIN..F_MAX / P_MIN..P_MAX; INC and DEC in the same cycle leave the target unchanged.
REQ-014 States: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, REVERSE=4.
REQ-015 IDLE: freqO=0, powerO=0, runO=0; a start pulse loads freqO=F_MIN, powerO=P_MIN, sets runO=1, and enters RAMP_UP.
REQ-016 RAMP_UP and RUN: on each tick, freqO and powerO SHALL each step 1 toward their targets without overshooting.
REQ-017 RAMP_UP SHALL enter RUN in the cycle after freqO==fTgt and powerO==pTgt both hold.
REQ-018 RUN or RAMP_UP: a start pulse SHALL enter RAMP_DOWN (stop request).
REQ-019 RUN or RAMP_UP: an invRotate pulse SHALL set revPending and enter RAMP_DOWN.
REQ-020 RAMP_DOWN: on each tick, freqO and powerO SHALL each step 1 toward F_MIN / P_MIN.
REQ-021 RAMP_DOWN exit: when freqO==F_MIN and powerO==P_MIN, go to REVERSE if revPending, else go to IDLE with outputs 0 and runO=0.
REQ-022 REVERSE: freqO=0, powerO=0, runO=0 for DEAD_TICKS ticks; then toggle dirO, clear revPending, load F_MIN/P_MIN, set runO=1, and enter RAMP_UP.
REQ-023 invRotate in IDLE SHALL toggle dirO immediately; start and invRotate pulses in RAMP_DOWN or REVERSE are ignored.
REQ-024 m3forceStopI high SHALL force IDLE on the next clock from any state, zero outputs, clear revPending, and block start while it stays high; dirO and targets are kept.
REQ-025 Priority within one cycle: forceStop > start > invRotate; INC/DEC are processed independently.
REQ-026 dirO SHALL change only in IDLE or at the REVERSE exit, never while runO=1.

Reset
REQ-027 rstI high at a clock edge SHALL set: state IDLE; freqO, powerO, runO, dirO, stateO all 0; fTgt=F_DEF; pTgt=P_DEF; tick counter 0; revPending 0.
REQ-028 Edge-detector history registers SHALL reset to 1, so an input held high through reset gives no press.
REQ-029 Reset asserted mid-ramp SHALL take effect in the same cycle as any other event, overriding it.

Structure
REQ-030 Package m3_pkg SHALL hold the state encoding constants and the default F_/P_ limit constants.
REQ-031 One sub-module, m3_edge_det (1-bit rising-edge detector with reset value 1), SHALL be instantiated once per edge-detected input.
REQ-032 Parameter legality SHALL be checked at elaboration: F_MIN<=F_DEF<=F_MAX, P_MIN<=P_DEF<=P_MAX, TICK_DIV>=2.

Verification (TICK_DIV=4, F 10/20/30, P 5/8/12, STEP=2, DEAD_TICKS=3)
REQ-033 start from IDLE -> freqO 10->20 over 10 ticks (40 clk), powerO 5->8 after 3 ticks, then stateO=2 with runO=1.
REQ-034 six freqINC presses in RUN -> fTgt saturates at 30; freqO climbs 1 per tick to 30; state stays RUN.
REQ-035 invRotate in RUN at 20/8 -> ramp down to 10/5, then REVERSE with zero outputs for 3 ticks, dirO 0->1, then ramp back up to 20/8.
REQ-036 forceStop mid RAMP_UP, start held high meanwhile -> next clk IDLE with all outputs 0; no restart until forceStop low and a new start edge.
REQ-037 freqINC+freqDEC in one cycle -> fTgt unchanged; rstI in RUN -> all outputs 0, fTgt=20, pTgt=8, dirO=0.
